// File: rtl/sm4_key_sched_if.sv
// SM4 key schedule handshake bundle: key intake on one side,
// round-key stream on the other.
interface sm4_key_sched_if;
  logic [127:0] key_in;
  logic         mode;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  rk_out;
  logic [4:0]   rk_idx;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output key_in,
    output mode,
    output in_valid,
    input  in_ready,
    input  rk_out,
    input  rk_idx,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  key_in,
    input  mode,
    input  in_valid,
    output in_ready,
    output rk_out,
    output rk_idx,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/sm4_key_sched.sv
// SM4 key expansion: RPC rounds per clock into a 32-word store,
// then streamed out in encrypt or decrypt order.
module sm4_key_sched #(
  parameter int RPC = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  sm4_key_sched_if.slave bus,
  output logic           busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  localparam logic [127:0] FK =
    128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  localparam logic [0:255][7:0] SBOX = {
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7,
    8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3,
    8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A,
    8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95,
    8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA,
    8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B,
    8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2,
    8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52,
    8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5,
    8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55,
    8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60,
    8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F,
    8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F,
    8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD,
    8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E,
    8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20,
    8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  logic [1:0]  state;
  logic [31:0] k [4];
  logic [4:0]  rnd;
  logic [4:0]  idx;
  logic        mode_q;
  logic [31:0] store [32];

  logic [31:0] w [4];
  logic [31:0] rk [RPC];
  logic        last_round;
  logic        last_beat;

  function automatic logic [31:0] ck(input logic [4:0] i);
    logic [31:0] c;
    logic [9:0]  p;
    c = '0;
    for (int j = 0; j < 4; j++) begin
      p = ({3'b000, i, 2'b00} + 10'(j)) * 10'd7;
      c[31-8*j -: 8] = p[7:0];
    end
    return c;
  endfunction

  function automatic logic [31:0] tp(input logic [31:0] x);
    logic [31:0] b;
    for (int j = 0; j < 4; j++)
      b[8*j +: 8] = SBOX[x[8*j +: 8]];
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // Window w slides forward one word per chained round.
  always_comb begin
    for (int j = 0; j < 4; j++)
      w[j] = k[j];
    for (int r = 0; r < RPC; r++) begin
      rk[r] = w[0] ^ tp(w[1] ^ w[2] ^ w[3] ^ ck(rnd + 5'(r)));
      w[0] = w[1];
      w[1] = w[2];
      w[2] = w[3];
      w[3] = rk[r];
    end
  end

  assign last_round = ({1'b0, rnd} + 6'(RPC)) == 6'd32;
  assign last_beat  = mode_q ? (idx == 5'd0) : (idx == 5'd31);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rnd    <= '0;
      idx    <= '0;
      mode_q <= 1'b0;
      for (int j = 0; j < 4; j++)
        k[j] <= '0;
    end else if (clear) begin
      state <= IDLE;
      rnd   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int j = 0; j < 4; j++)
              k[j] <= bus.key_in[127-32*j -: 32]
                    ^ FK[127-32*j -: 32];
            mode_q <= bus.mode;
            rnd    <= '0;
            idx    <= bus.mode ? 5'd31 : 5'd0;
            state  <= EXPAND;
          end
        end
        EXPAND: begin
          for (int j = 0; j < 4; j++)
            k[j] <= w[j];
          rnd <= rnd + 5'(RPC);
          if (last_round)
            state <= STREAM;
        end
        STREAM: begin
          if (bus.out_ready) begin
            if (last_beat)
              state <= IDLE;
            else
              idx <= mode_q ? idx - 5'd1 : idx + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Store needs no reset; it is fully rewritten before any read.
  always_ff @(posedge clk) begin
    if (state == EXPAND)
      for (int r = 0; r < RPC; r++)
        store[rnd + 5'(r)] <= rk[r];
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == STREAM);
  assign bus.rk_out    = bus.out_valid ? store[idx] : 32'd0;
  assign bus.rk_idx    = bus.out_valid ? idx : 5'd0;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_sm4_key_sched.sv
// Bench for sm4_key_sched: four RPC variants in parallel against
// a round-by-round SM4 key schedule model.
module tb_sm4_key_sched;

  localparam logic [127:0] STD =
    128'h01234567_89ABCDEF_FEDCBA98_76543210;

  localparam logic [31:0] FKW [4] = '{
    32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC
  };

  localparam logic [7:0] SB [256] = '{
    8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7,
    8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
    8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3,
    8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A,
    8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
    8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95,
    8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
    8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA,
    8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
    8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B,
    8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
    8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2,
    8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52,
    8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
    8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5,
    8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
    8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55,
    8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
    8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60,
    8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
    8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F,
    8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
    8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F,
    8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
    8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD,
    8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
    8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E,
    8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
    8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20,
    8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
  };

  localparam int RPCV [4] = '{1, 2, 4, 8};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic [127:0] key_in;
  logic         mode;
  logic         in_valid;
  logic         out_ready;

  logic        ov [4];
  logic        bz [4];
  logic        ir [4];
  logic [31:0] ro [4];
  logic [4:0]  ri [4];

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_rk [32];
  logic [31:0] got [32];

  always #5 clk = ~clk;

  sm4_key_sched_if if0 ();
  sm4_key_sched_if if1 ();
  sm4_key_sched_if if2 ();
  sm4_key_sched_if if3 ();

  assign if0.key_in = key_in;
  assign if0.mode = mode;
  assign if0.in_valid = in_valid;
  assign if0.out_ready = out_ready;
  assign if1.key_in = key_in;
  assign if1.mode = mode;
  assign if1.in_valid = in_valid;
  assign if1.out_ready = out_ready;
  assign if2.key_in = key_in;
  assign if2.mode = mode;
  assign if2.in_valid = in_valid;
  assign if2.out_ready = out_ready;
  assign if3.key_in = key_in;
  assign if3.mode = mode;
  assign if3.in_valid = in_valid;
  assign if3.out_ready = out_ready;

  assign ov[0] = if0.out_valid;
  assign ov[1] = if1.out_valid;
  assign ov[2] = if2.out_valid;
  assign ov[3] = if3.out_valid;
  assign ir[0] = if0.in_ready;
  assign ir[1] = if1.in_ready;
  assign ir[2] = if2.in_ready;
  assign ir[3] = if3.in_ready;
  assign ro[0] = if0.rk_out;
  assign ro[1] = if1.rk_out;
  assign ro[2] = if2.rk_out;
  assign ro[3] = if3.rk_out;
  assign ri[0] = if0.rk_idx;
  assign ri[1] = if1.rk_idx;
  assign ri[2] = if2.rk_idx;
  assign ri[3] = if3.rk_idx;

  sm4_key_sched #(.RPC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bus(if0.slave), .busy(bz[0]));
  sm4_key_sched #(.RPC(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bus(if1.slave), .busy(bz[1]));
  sm4_key_sched #(.RPC(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bus(if2.slave), .busy(bz[2]));
  sm4_key_sched #(.RPC(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bus(if3.slave), .busy(bz[3]));

  function automatic logic [31:0] rotl(input logic [31:0] v,
                                       input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic void build(input logic [127:0] mk);
    logic [31:0] kk [36];
    logic [31:0] x, b, c;
    for (int j = 0; j < 4; j++)
      kk[j] = mk[127-32*j -: 32] ^ FKW[j];
    for (int i = 0; i < 32; i++) begin
      c = 0;
      for (int j = 0; j < 4; j++)
        c = (c << 8) | 32'(((4 * i + j) * 7) % 256);
      x = kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ c;
      b = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
      kk[i+4] = kk[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      exp_rk[i] = kk[i+4];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s_ov%0d", tag, d), 32'(ov[d]), 0);
      chk($sformatf("%s_bz%0d", tag, d), 32'(bz[d]), 0);
      chk($sformatf("%s_ir%0d", tag, d), 32'(ir[d]), 1);
      chk($sformatf("%s_ro%0d", tag, d), ro[d], 0);
      chk($sformatf("%s_ri%0d", tag, d), 32'(ri[d]), 0);
    end
  endtask

  task automatic start_key(input logic [127:0] key, input logic md);
    int n = 0;
    while (!(ir[0] && ir[1] && ir[2] && ir[3]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(ir[0] & ir[1] & ir[2] & ir[3]), 1);
    key_in = key;
    mode = md;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_stream(input logic [127:0] key, input logic md,
                            input bit bp, input bit hold);
    bit done [4];
    bit fin [4];
    bit stall [4];
    int beats [4];
    int ecnt [4];
    logic [31:0] lro [4];
    logic [4:0] lri [4];
    logic [4:0] ei;
    bit all;
    build(key);
    start_key(key, md);
    if (hold) begin
      key_in = ~key;
      mode = ~md;
      in_valid = 1'b1;
    end
    for (int d = 0; d < 4; d++) begin
      done[d] = 0; fin[d] = 0; stall[d] = 0;
      beats[d] = 0; ecnt[d] = 0;
    end
    all = 0;
    for (int c = 0; c < 600 && !all; c++) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      for (int d = 0; d < 4; d++) begin
        if (done[d]) continue;
        if (fin[d]) begin
          chk($sformatf("end_ov%0d", d), 32'(ov[d]), 0);
          chk($sformatf("end_bz%0d", d), 32'(bz[d]), 0);
          chk($sformatf("end_ir%0d", d), 32'(ir[d]), 1);
          chk($sformatf("exp_len%0d", d), ecnt[d], 32 / RPCV[d]);
          done[d] = 1;
        end else if (ov[d]) begin
          chk($sformatf("busy_ir%0d", d), 32'(ir[d]), 0);
          if (stall[d]) begin
            chk($sformatf("hold_ro%0d", d), ro[d], lro[d]);
            chk($sformatf("hold_ri%0d", d), 32'(ri[d]), 32'(lri[d]));
          end
          ei = md ? 5'(31 - beats[d]) : 5'(beats[d]);
          if (out_ready) begin
            chk($sformatf("idx%0d", d), 32'(ri[d]), 32'(ei));
            chk($sformatf("rk%0d", d), ro[d], exp_rk[ei]);
            if (d == 0) got[beats[0]] = ro[0];
            beats[d]++;
            stall[d] = 0;
            if (beats[d] == 32) fin[d] = 1;
          end else begin
            stall[d] = 1;
            lro[d] = ro[d];
            lri[d] = ri[d];
          end
        end else if (bz[d]) begin
          chk($sformatf("busy_ir%0d", d), 32'(ir[d]), 0);
          chk($sformatf("no_gap%0d", d), beats[d], 0);
          ecnt[d]++;
        end
      end
      all = done[0] && done[1] && done[2] && done[3];
      @(negedge clk);
    end
    for (int d = 0; d < 4; d++)
      chk($sformatf("finished%0d", d), 32'(done[d]), 1);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic wait_beat(input logic [4:0] target);
    int n = 0;
    while (!(ov[0] && ri[0] == target) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("beat_wait", 32'(ov[0] && ri[0] == target), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    key_in = '0;
    mode = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_idle("reset");

    run_stream(STD, 1'b0, 0, 0);
    chk("std0_first", got[0], 32'hF12186F9);
    chk("std0_second", got[1], 32'h41662B61);
    chk("std0_last", got[31], 32'h9124A012);

    run_stream(STD, 1'b1, 0, 0);
    chk("std1_first", got[0], 32'h9124A012);
    chk("std1_last", got[31], 32'hF12186F9);

    for (int t = 0; t < 3; t++)
      run_stream({$urandom, $urandom, $urandom, $urandom},
                 1'($urandom_range(0, 1)), 1, 0);

    start_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_idle("clr_exp");

    clear = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    chk_idle("clr_vs_valid");
    run_stream({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1, 0);

    out_ready = 1'b1;
    start_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);
    wait_beat(5'd10);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    out_ready = 1'b0;
    chk_idle("clr_stream");
    run_stream({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1, 0);

    out_ready = 1'b1;
    start_key(STD, 1'b1);
    wait_beat(5'd25);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    chk_idle("rst_stream");

    run_stream(STD, 1'b0, 1, 1);
    chk("hold_first", got[0], 32'hF12186F9);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
